// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the fetch/memory SRAM arbiter.
// Holds the FSM state encoding, requester ids and the arbitration rule.
package arm_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // Contention goes to whichever side did not win last time.
  function automatic logic pick_mem(input logic if_pend, input logic mem_pend,
                                    input logic last_grant);
    return mem_pend && (!if_pend || (last_grant == REQ_IF));
  endfunction

endpackage

// File: rtl/sram_fetch_arbiter_access_timer.sv
// Loadable down-counter with a zero flag, used to count SRAM wait states.
// Load has priority over decrement; the count saturates at zero.
module access_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_fetch_arbiter.sv
// Arbitrates a single-port fixed-latency SRAM between instruction fetch and the memory stage.
// state  | meaning
// IDLE   | pick a requester, latch its op/addr/wdata, load the wait timer
// ACCESS | drive the SRAM for WAIT_CYCLES cycles, capture read data on the last one
// DONE   | one-cycle ready pulse to the winner; requests ignored (bubble)
module sram_fetch_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam logic [3:0] TMR_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_id_q, gnt_id_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [WORD_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;

  logic mem_pend;
  logic grant_mem;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  // Byte-offset and out-of-range address bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  assign mem_pend  = mem_rd | mem_wr;
  assign grant_mem = pick_mem(if_req, mem_pend, last_grant_q);

  access_timer #(.CNT_W(4)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TMR_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_pend || if_req) begin
          tmr_load  = 1'b1;
          sram_en_d = 1'b1;
          state_d   = ACCESS;
          if (grant_mem) begin
            gnt_id_d     = REQ_MEM;
            last_grant_d = REQ_MEM;
            sram_we_d    = mem_wr;
            sram_addr_d  = mem_addr[ADDR_W+1:2];
            sram_wdata_d = mem_wdata;
          end else begin
            gnt_id_d     = REQ_IF;
            last_grant_d = REQ_IF;
            sram_we_d    = 1'b0;
            sram_addr_d  = if_addr[ADDR_W+1:2];
          end
        end
      end
      ACCESS: begin
        if (tmr_zero) begin
          sram_en_d = 1'b0;
          sram_we_d = 1'b0;
          state_d   = DONE;
          if (gnt_id_q == REQ_MEM) begin
            mem_ready_d = 1'b1;
            if (!sram_we_q) begin
              mem_rdata_d = sram_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = sram_rdata;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        sram_en_d = 1'b0;
        sram_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_IF;
      gnt_id_q     <= REQ_IF;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_ready  = mem_ready_q;

endmodule

// File: doc/sram_fetch_arbiter.md
Name: sram_fetch_arbiter

Overview:
- Shares one single-port, fixed-latency SRAM between two requesters: the instruction-fetch stage (read only) and the memory stage (read/write).
- Sits between the pipeline and the memory macro.
- Sequences each SRAM access through a small FSM and returns a one-cycle ready pulse to the winning requester.
- The pipeline derives its freeze from the requester's request being high while its ready is low.

Parameters:
- ADDR_W, 16: SRAM word-address width.
- WAIT_CYCLES, 3: SRAM access cycles per transfer. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch read request, level
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch read data
- if_ready  out  1  fetch completion pulse
- mem_rd  in  1  data read request, level
- mem_wr  in  1  data write request, level
- mem_addr  in  32  data byte address
- mem_wdata  in  32  write data
- mem_rdata  out  32  data read data
- mem_ready  out  1  data completion pulse
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid on the last access cycle

Behaviour:
- Interface: clock clk; reset rst, asynchronous, active-high.
- Reset: all outputs 0; FSM goes to IDLE; wait counter = 0; last_grant = IF.
- Reset mid-access aborts the access; sram_en and sram_we fall asynchronously.
- FSM states: IDLE, ACCESS, DONE.
- IDLE arbitration:
  - Only MEM pending (mem_rd|mem_wr): grant MEM.
  - Only if_req pending: grant IF.
  - Both pending: grant the requester opposite to last_grant (alternation, no starvation).
  - Nothing pending: stay in IDLE.
- On a grant:
  - Latch requester id, op (read/write), sram_addr = addr[ADDR_W+1:2], and wdata.
  - Update last_grant.
  - Load counter = WAIT_CYCLES-1; go to ACCESS.
  - Address bits [1:0] and bits above ADDR_W+1 are ignored.
- mem_rd and mem_wr both high: treated as a write.
- ACCESS:
  - sram_en = 1; sram_we = 1 only for writes.
  - sram_addr and sram_wdata are held stable from the latched values.
  - Counter decrements each cycle.
  - When counter == 0: capture sram_rdata into the granted requester's rdata register (reads only); go to DONE.
- DONE:
  - sram_en = 0.
  - The granted requester's ready = 1 for exactly this cycle.
  - Go to IDLE unconditionally.
  - Requests are not sampled in DONE, giving a one-cycle bubble.
- Latency: grant in IDLE at cycle t; ACCESS during t+1 .. t+WAIT_CYCLES; ready pulse in cycle t+WAIT_CYCLES+1. Occupancy is WAIT_CYCLES+2 cycles per transfer.
- Read data: if_rdata and mem_rdata are registered and hold their value until that requester's next read completes. A write leaves mem_rdata unchanged.
- Request rules:
  - Requesters hold req and addr stable until ready.
  - A request dropped before grant is not serviced.
  - A request dropped after grant still completes; the ready pulse is issued and may be ignored.
  - Address or data changes after grant have no effect on the current access.
- if_ready and mem_ready are never high in the same cycle. sram_we is never high without sram_en.

Decomposition:
- Shared package (arm_mem_pkg):
  - FSM state encoding constants: IDLE, ACCESS, DONE.
  - Requester id constants: REQ_IF, REQ_MEM.
  - WORD_W = 32.
- One natural sub-module: access_timer, a loadable down-counter with a zero flag, width 4, for the wait-state count.
- Arbitration and FSM stay in the top module.

Test Plan:
- Fetch only: WAIT_CYCLES = 3, if_req = 1, if_addr = 0x0000_0008, SRAM word 2 = 0xE3A0_1005 -> sram_en high for cycles 1-3 with sram_addr = 2; if_ready pulses in cycle 4 with if_rdata = 0xE3A0_1005.
- Simultaneous requests after reset: if_req and mem_rd both high, last_grant = IF -> MEM is served first, then IF. Grants alternate IF/MEM while both stay high; no two ready pulses in the same cycle.
- Write then read: mem_wr with addr 0x0000_0100 and wdata 0xDEAD_BEEF -> sram_we = 1 for 3 cycles at word 0x40, then mem_ready pulses. A following mem_rd to the same address returns 0xDEAD_BEEF; if_rdata is unchanged.
- Held data: after an IF read returns 0x1234_5678, deassert if_req for 10 cycles -> if_rdata stays 0x1234_5678 and if_ready stays 0.
- Reset mid-access: assert rst in the 2nd ACCESS cycle of a write -> sram_en and sram_we go to 0 immediately, no ready pulse occurs, FSM is in IDLE after rst falls, and a new if_req is then serviced normally.
- WAIT_CYCLES = 1 build: back-to-back if_req -> ready pulse every 3 cycles; the address change between requests is picked up on the next grant.
